mem_stage_lsu: RTL and testbench

- MEM-stage load/store unit. It consumes the EX/MEM pipeline register outputs and performs the word access to data memory over a req/gnt/rvalid handshake.
- It holds the pipeline through `stall_o` while an access is in flight, then loads the MEM/WB register.
- It forwards the branch redirect to the fetch stage.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/mem_wb_reg.sv | 40 ++++
 rtl/mem_stage_lsu.sv | 181 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
//   lsu_state_t   : access FSM states (IDLE, REQ, WAIT)
//   DADDR_W_DEF   : default data-memory word-address width
//   TIMEOUT_DEF   : default access timeout in cycles
//   REG_ADDR_W    : register-file index width
//   XLEN          : data path width
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_t;

  localparam int DADDR_W_DEF = 14;
  localparam int TIMEOUT_DEF = 255;
  localparam int REG_ADDR_W  = 5;
  localparam int XLEN        = 32;

  // Word accesses need the two low byte-address bits clear.
  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with a load enable.
//   clk, rst_n  : clock, asynchronous active-low reset (clears everything)
//   load        : capture the inputs at the rising edge
//   reg_write, mem_to_reg, alu_result, rdata, rd : next MEM/WB contents
//   wb_*        : registered MEM/WB contents
module mem_wb_reg
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  reg_write,
  input  logic                  mem_to_reg,
  input  logic [XLEN-1:0]       alu_result,
  input  logic [XLEN-1:0]       rdata,
  input  logic [REG_ADDR_W-1:0] rd,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [XLEN-1:0]       wb_alu_result,
  output logic [XLEN-1:0]       wb_rdata,
  output logic [REG_ADDR_W-1:0] wb_rd
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_alu_result <= '0;
      wb_rdata      <= '0;
      wb_rd         <= '0;
    end else if (load) begin
      wb_reg_write  <= reg_write;
      wb_mem_to_reg <= mem_to_reg;
      wb_alu_result <= alu_result;
      wb_rdata      <= rdata;
      wb_rd         <= rd;
    end
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit.
//   EX/MEM inputs : RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, Branch_i,
//                   ALUResult_i, rdata2_i, rd_i, addr_jump_i
//   data memory   : dmem_req_o/we_o/addr_o/wdata_o out, dmem_gnt_i/rvalid_i/rdata_i in
//   pipeline      : stall_o freezes upstream stages while an access is in flight
//   fetch         : pc_src_o / pc_target_o forward the branch redirect
//   MEM/WB        : RegWrite_o, MemtoReg_o, rdata_o, ALUResult_o, rd_o
//   err_o         : one-cycle pulse on misaligned access or timeout abort
module mem_stage_lsu
  import cpu_pkg::*;
#(
  parameter int DADDR_W = DADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWrite_i,
  input  logic                  MemRead_i,
  input  logic                  MemWrite_i,
  input  logic                  MemtoReg_i,
  input  logic                  Branch_i,
  input  logic [XLEN-1:0]       ALUResult_i,
  input  logic [XLEN-1:0]       rdata2_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic [13:0]           addr_jump_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [DADDR_W-1:0]    dmem_addr_o,
  output logic [XLEN-1:0]       dmem_wdata_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [XLEN-1:0]       dmem_rdata_i,
  output logic                  stall_o,
  output logic                  pc_src_o,
  output logic [13:0]           pc_target_o,
  output logic                  RegWrite_o,
  output logic                  MemtoReg_o,
  output logic [XLEN-1:0]       rdata_o,
  output logic [XLEN-1:0]       ALUResult_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic                  err_o
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  lsu_state_t          state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                req_next, we_next, err_next;
  logic [DADDR_W-1:0]  addr_next;
  logic [XLEN-1:0]     wdata_next;
  logic                stall, wb_load, wb_reg_write;
  logic [XLEN-1:0]     wb_rdata;
  logic                mem_op, misaligned, at_limit;

  assign pc_src_o    = Branch_i;
  assign pc_target_o = addr_jump_i;

  assign mem_op     = MemRead_i | MemWrite_i;
  assign misaligned = is_misaligned(ALUResult_i[1:0]);
  assign at_limit   = (cnt_reg == CNT_LIMIT);

  // The FSM is forced to IDLE during reset, but an access still presented on
  // EX/MEM would otherwise raise stall there; keep upstream free while reset.
  assign stall_o = stall & rst_n;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    req_next     = dmem_req_o;
    we_next      = dmem_we_o;
    addr_next    = dmem_addr_o;
    wdata_next   = dmem_wdata_o;
    err_next     = 1'b0;
    stall        = 1'b0;
    wb_load      = 1'b0;
    wb_reg_write = RegWrite_i;
    wb_rdata     = '0;

    case (state_reg)
      IDLE: begin
        if (!mem_op) begin
          wb_load = 1'b1;
        end else if (misaligned) begin
          wb_load      = 1'b1;
          wb_reg_write = 1'b0;
          err_next     = 1'b1;
        end else begin
          stall      = 1'b1;
          state_next = REQ;
          cnt_next   = '0;
          req_next   = 1'b1;
          we_next    = MemWrite_i & ~MemRead_i;
          addr_next  = ALUResult_i[DADDR_W+1:2];
          wdata_next = rdata2_i;
        end
      end

      REQ: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (dmem_gnt_i && dmem_we_o) begin
          // Granted write finishes in the grant cycle.
          wb_load    = 1'b1;
          req_next   = 1'b0;
          state_next = IDLE;
        end else if (at_limit) begin
          // A granted read is not yet a completion, so the limit still aborts it.
          wb_load      = 1'b1;
          wb_reg_write = 1'b0;
          err_next     = 1'b1;
          req_next     = 1'b0;
          state_next   = IDLE;
        end else if (dmem_gnt_i) begin
          stall      = 1'b1;
          req_next   = 1'b0;
          state_next = WAIT;
        end else begin
          stall = 1'b1;
        end
      end

      WAIT: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (dmem_rvalid_i) begin
          wb_load    = 1'b1;
          wb_rdata   = dmem_rdata_i;
          state_next = IDLE;
        end else if (at_limit) begin
          wb_load      = 1'b1;
          wb_reg_write = 1'b0;
          err_next     = 1'b1;
          state_next   = IDLE;
        end else begin
          stall = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      err_o        <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      dmem_req_o   <= req_next;
      dmem_we_o    <= we_next;
      dmem_addr_o  <= addr_next;
      dmem_wdata_o <= wdata_next;
      err_o        <= err_next;
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (wb_load),
    .reg_write     (wb_reg_write),
    .mem_to_reg    (MemtoReg_i),
    .alu_result    (ALUResult_i),
    .rdata         (wb_rdata),
    .rd            (rd_i),
    .wb_reg_write  (RegWrite_o),
    .wb_mem_to_reg (MemtoReg_o),
    .wb_alu_result (ALUResult_o),
    .wb_rdata      (rdata_o),
    .wb_rd         (rd_o)
  );

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, Branch_i;
  logic [31:0] ALUResult_i, rdata2_i;
  logic [4:0]  rd_i;
  logic [13:0] addr_jump_i;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  logic        dmem_req_o, dmem_we_o, stall_o, pc_src_o;
  logic [13:0] dmem_addr_o, pc_target_o;
  logic [31:0] dmem_wdata_o, rdata_o, ALUResult_o;
  logic        RegWrite_o, MemtoReg_o, err_o;
  logic [4:0]  rd_o;

  // Second instance with a short timeout; it has its own memory handshake.
  logic        to_gnt, to_rvalid;
  logic [31:0] to_rdata_in;
  logic        to_req, to_we, to_stall, to_pc_src, to_regwrite, to_memtoreg, to_err;
  logic [13:0] to_addr, to_pc_target;
  logic [31:0] to_wdata, to_rdata, to_alu;
  logic [4:0]  to_rd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .RegWrite_i(RegWrite_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .MemtoReg_i(MemtoReg_i), .Branch_i(Branch_i), .ALUResult_i(ALUResult_i),
    .rdata2_i(rdata2_i), .rd_i(rd_i), .addr_jump_i(addr_jump_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o), .pc_src_o(pc_src_o),
    .pc_target_o(pc_target_o), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
    .rdata_o(rdata_o), .ALUResult_o(ALUResult_o), .rd_o(rd_o), .err_o(err_o)
  );

  mem_stage_lsu #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rst_n(rst_n),
    .RegWrite_i(RegWrite_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .MemtoReg_i(MemtoReg_i), .Branch_i(Branch_i), .ALUResult_i(ALUResult_i),
    .rdata2_i(rdata2_i), .rd_i(rd_i), .addr_jump_i(addr_jump_i),
    .dmem_req_o(to_req), .dmem_we_o(to_we), .dmem_addr_o(to_addr),
    .dmem_wdata_o(to_wdata), .dmem_gnt_i(to_gnt), .dmem_rvalid_i(to_rvalid),
    .dmem_rdata_i(to_rdata_in), .stall_o(to_stall), .pc_src_o(to_pc_src),
    .pc_target_o(to_pc_target), .RegWrite_o(to_regwrite), .MemtoReg_o(to_memtoreg),
    .rdata_o(to_rdata), .ALUResult_o(to_alu), .rd_o(to_rd), .err_o(to_err)
  );

  task automatic set_bubble();
    RegWrite_i = 0; MemRead_i = 0; MemWrite_i = 0; MemtoReg_i = 0; Branch_i = 0;
    ALUResult_i = 0; rdata2_i = 0; rd_i = 0; addr_jump_i = 0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (dmem_req_o !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", dmem_req_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
    checks++; if ({RegWrite_o, MemtoReg_o, err_o, rd_o} !== 8'h00) begin
      failures++; $display("FAIL reset_wb_ctl got=%h exp=00", {RegWrite_o, MemtoReg_o, err_o, rd_o}); end
    checks++; if ({rdata_o, ALUResult_o, dmem_wdata_o, dmem_addr_o, dmem_we_o} !== '0) begin
      failures++; $display("FAIL reset_data got_rdata=%h alu=%h wdata=%h addr=%h exp=0",
                           rdata_o, ALUResult_o, dmem_wdata_o, dmem_addr_o); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("tx reset done");
  endtask

  task automatic test_non_mem();
    RegWrite_i = 1; ALUResult_i = 32'h1234; rd_i = 5'd7;
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL nonmem_stall got=%b exp=0", stall_o); end
    @(negedge clk);
    checks++; if (dmem_req_o !== 1'b0) begin failures++; $display("FAIL nonmem_req got=%b exp=0", dmem_req_o); end
    checks++; if (ALUResult_o !== 32'h1234 || rd_o !== 5'd7 || RegWrite_o !== 1'b1) begin
      failures++; $display("FAIL nonmem_wb got alu=%h rd=%0d rw=%b exp alu=1234 rd=7 rw=1",
                           ALUResult_o, rd_o, RegWrite_o); end
    set_bubble();
    $display("tx non_mem alu=%h rd=%0d", ALUResult_o, rd_o);
  endtask

  task automatic test_store();
    MemWrite_i = 1; ALUResult_i = 32'h40; rdata2_i = 32'hDEADBEEF; rd_i = 5'd1;
    #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL store_stall_idle got=%b exp=1", stall_o); end
    @(negedge clk);
    checks++; if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b1 || dmem_addr_o !== 14'h10 || dmem_wdata_o !== 32'hDEADBEEF) begin
      failures++; $display("FAIL store_req got req=%b we=%b addr=%h wdata=%h exp req=1 we=1 addr=0010 wdata=deadbeef",
                           dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o); end
    dmem_gnt_i = 1;
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL store_complete_stall got=%b exp=0", stall_o); end
    @(negedge clk);
    dmem_gnt_i = 0;
    checks++; if (dmem_req_o !== 1'b0 || ALUResult_o !== 32'h40 || rdata_o !== 32'h0 || rd_o !== 5'd1) begin
      failures++; $display("FAIL store_wb got req=%b alu=%h rdata=%h rd=%0d exp req=0 alu=40 rdata=0 rd=1",
                           dmem_req_o, ALUResult_o, rdata_o, rd_o); end
    set_bubble();
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL store_after_stall got=%b exp=0", stall_o); end
    $display("tx store addr=%h wdata=%h", dmem_addr_o, dmem_wdata_o);
  endtask

  task automatic test_load_delayed();
    int stall_cnt = 0;
    int req_cnt = 0;
    int req_bad = 0;
    int br_bad = 0;
    MemRead_i = 1; RegWrite_i = 1; MemtoReg_i = 1; ALUResult_i = 32'h80; rd_i = 5'd5;
    Branch_i = 1; addr_jump_i = 14'h0A0;
    for (int k = 0; k < 7; k++) begin
      dmem_gnt_i    = (k == 4);
      dmem_rvalid_i = (k == 6);
      dmem_rdata_i  = (k == 6) ? 32'hCAFEF00D : 32'h11111111;
      #1;
      if (stall_o) stall_cnt++;
      if (dmem_req_o) begin
        req_cnt++;
        if (dmem_addr_o !== 14'h20 || dmem_we_o !== 1'b0) req_bad++;
      end
      if (pc_src_o !== 1'b1 || pc_target_o !== 14'h0A0) br_bad++;
      @(negedge clk);
    end
    dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
    checks++; if (stall_cnt != 6) begin failures++; $display("FAIL load_stall_cycles got=%0d exp=6", stall_cnt); end
    checks++; if (req_cnt != 4) begin failures++; $display("FAIL load_req_cycles got=%0d exp=4", req_cnt); end
    checks++; if (req_bad != 0) begin failures++; $display("FAIL load_req_stable got_bad=%0d exp=0", req_bad); end
    checks++; if (br_bad != 0) begin failures++; $display("FAIL branch_fwd got_bad=%0d exp=0", br_bad); end
    checks++; if (rdata_o !== 32'hCAFEF00D || rd_o !== 5'd5 || MemtoReg_o !== 1'b1 || RegWrite_o !== 1'b1) begin
      failures++; $display("FAIL load_wb got rdata=%h rd=%0d m2r=%b rw=%b exp rdata=cafef00d rd=5 m2r=1 rw=1",
                           rdata_o, rd_o, MemtoReg_o, RegWrite_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL load_err got=%b exp=0", err_o); end
    set_bubble();
    $display("tx load rdata=%h stall_cycles=%0d", rdata_o, stall_cnt);
  endtask

  task automatic test_misaligned();
    MemRead_i = 1; RegWrite_i = 1; ALUResult_i = 32'h42; rd_i = 5'd3;
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL misal_stall got=%b exp=0", stall_o); end
    @(negedge clk);
    checks++; if (dmem_req_o !== 1'b0) begin failures++; $display("FAIL misal_req got=%b exp=0", dmem_req_o); end
    checks++; if (err_o !== 1'b1 || RegWrite_o !== 1'b0 || rdata_o !== 32'h0) begin
      failures++; $display("FAIL misal_wb got err=%b rw=%b rdata=%h exp err=1 rw=0 rdata=0", err_o, RegWrite_o, rdata_o); end
    set_bubble();
    @(negedge clk);
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL misal_err_pulse got=%b exp=0", err_o); end
    $display("tx misaligned addr=%h", 32'h42);
  endtask

  task automatic test_reset_mid();
    RegWrite_i = 1; ALUResult_i = 32'h55; rd_i = 5'd4;
    @(negedge clk);
    MemRead_i = 1; RegWrite_i = 1; ALUResult_i = 32'h44; rd_i = 5'd2;
    @(negedge clk);
    dmem_gnt_i = 1;
    @(negedge clk);
    dmem_gnt_i = 0;
    #1;
    checks++; if (stall_o !== 1'b1 || ALUResult_o !== 32'h55) begin
      failures++; $display("FAIL rstmid_wait got stall=%b alu=%h exp stall=1 alu=55", stall_o, ALUResult_o); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (dmem_req_o !== 1'b0 || stall_o !== 1'b0 || err_o !== 1'b0) begin
      failures++; $display("FAIL rstmid_ctl got req=%b stall=%b err=%b exp 0", dmem_req_o, stall_o, err_o); end
    checks++; if ({RegWrite_o, MemtoReg_o, rd_o} !== 7'h0 || ALUResult_o !== 32'h0 || rdata_o !== 32'h0) begin
      failures++; $display("FAIL rstmid_wb got rw=%b m2r=%b rd=%0d alu=%h rdata=%h exp 0",
                           RegWrite_o, MemtoReg_o, rd_o, ALUResult_o, rdata_o); end
    set_bubble();
    dmem_gnt_i = 1; dmem_rvalid_i = 1; dmem_rdata_i = 32'h99999999;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (dmem_req_o !== 1'b0 || stall_o !== 1'b0 || rdata_o !== 32'h0 || err_o !== 1'b0) begin
      failures++; $display("FAIL rstmid_after got req=%b stall=%b rdata=%h err=%b exp 0",
                           dmem_req_o, stall_o, rdata_o, err_o); end
    dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
    $display("tx reset_mid done");
  endtask

  task automatic test_timeout();
    int stall_cnt = 0;
    MemRead_i = 1; RegWrite_i = 1; ALUResult_i = 32'h100; rd_i = 5'd9;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (!to_stall) break;
      stall_cnt++;
      @(negedge clk);
    end
    checks++; if (stall_cnt != 5) begin failures++; $display("FAIL timeout_stall_cycles got=%0d exp=5", stall_cnt); end
    @(negedge clk);
    checks++; if (to_err !== 1'b1 || to_regwrite !== 1'b0 || to_req !== 1'b0 || to_rdata !== 32'h0) begin
      failures++; $display("FAIL timeout_abort got err=%b rw=%b req=%b rdata=%h exp err=1 rw=0 req=0 rdata=0",
                           to_err, to_regwrite, to_req, to_rdata); end
    set_bubble();
    to_gnt = 1; to_rvalid = 1; to_rdata_in = 32'h77777777;
    @(negedge clk);
    to_gnt = 0; to_rvalid = 0; to_rdata_in = 0;
    checks++; if (to_req !== 1'b0 || to_err !== 1'b0 || to_stall !== 1'b0 || to_rdata !== 32'h0) begin
      failures++; $display("FAIL timeout_late_gnt got req=%b err=%b stall=%b rdata=%h exp 0",
                           to_req, to_err, to_stall, to_rdata); end
    $display("tx timeout stall_cycles=%0d", stall_cnt);
  endtask

  initial begin
    set_bubble();
    dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
    to_gnt = 0; to_rvalid = 0; to_rdata_in = 0;
    test_reset();
    test_non_mem();
    test_store();
    test_load_delayed();
    test_misaligned();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
